mem_access: RTL

- MEM stage of the cqu_mips five-stage pipeline; the consumer end of the execute stage's outputs.
- Registers the execute results (alu_result, write_reg, reg_write, mem_to_reg, mem_read, mem_write) and drives the data-memory request/response handshake.
- Performs byte-lane alignment for stores and sign/zero extension for loads.
- Stalls the front of the pipeline until an access completes, then presents one writeback beat.

---
 rtl/mem_access_pkg.sv | 44 ++++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_access.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the MEM stage and its lane aligner.
package mem_access_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   // Access size codes carried on mem_size / data_size.
   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

   // Bus handshake FSM.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Contents of the EX/MEM pipeline register.
   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] store_data;
      logic              mem_read;
      logic              mem_write;
      logic [1:0]        size;
      logic              sext;
      logic [REG_W-1:0]  write_reg;
      logic              reg_write;
      logic              mem_to_reg;
   } m_reg_t;

   // Natural-alignment test; size code 2'b11 is treated like a word.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (size[1])
         bad = (addr_lo != 2'b00);
      else if (size == MEM_SIZE_HALF)
         bad = addr_lo[0];
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication/strobes and load extract/extend.
// Purely combinational so a cache path can reuse it unchanged.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]        size,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] rdata,
   input  logic              sext,
   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   output logic [DATA_W-1:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Replicate the store operand across all lanes; strobes pick the lanes.
   always_comb begin
      wdata = store_data;
      wstrb = 4'b1111;
      case (size)
         MEM_SIZE_BYTE: begin
            wdata = {4{store_data[7:0]}};
            wstrb = 4'b0001 << addr_lo;
         end
         MEM_SIZE_HALF: begin
            wdata = {2{store_data[15:0]}};
            wstrb = 4'b0011 << addr_lo;
         end
         default: ;
      endcase
   end

   assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
   assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   // Pull the addressed lane(s) down to bit 0 and extend.
   always_comb begin
      load_data = rdata;
      case (size)
         MEM_SIZE_BYTE: load_data = {{24{sext & byte_sel[7]}}, byte_sel};
         MEM_SIZE_HALF: load_data = {{16{sext & half_sel[15]}}, half_sel};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM stage: EX/MEM register, data-bus request/response FSM, writeback beat
// and address-error detection.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ALIGN_CHECK = 1,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       store_data,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic [1:0]        mem_size,
   input  logic              mem_sext,
   input  logic [4:0]        write_reg,
   input  logic              reg_write_in,
   input  logic              mem_to_reg_in,
   output logic              mem_stall,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_waddr,
   output logic [31:0]       wb_wdata,
   output logic              adel,
   output logic              ades,
   output logic [ADDR_W-1:0] bad_vaddr
);

   state_t      state, state_nx;
   m_reg_t      m_q;
   logic        complete;
   logic        ex_mem, ex_misalign;
   logic        m_mem, m_misalign, m_fault;
   logic        bus_active;
   logic [1:0]  lane_a;
   logic [3:0]  lane_wstrb;
   logic [31:0] lane_wdata, load_data;

   assign ex_mem      = mem_read_in | mem_write_in;
   assign ex_misalign = (ALIGN_CHECK != 0) && misaligned(mem_size, alu_result[1:0]);
   assign m_mem       = m_q.mem_read | m_q.mem_write;
   assign m_misalign  = (ALIGN_CHECK != 0) && misaligned(m_q.size, m_q.alu_result[1:0]);

   // Only misaligned accesses sit in M while the FSM is idle; those fault.
   assign m_fault    = (state == ST_IDLE) && m_q.valid && m_mem && m_misalign;
   assign bus_active = (state != ST_IDLE);

   // Next state plus the stall/request/complete controls. A zero-wait
   // completion in REQ drops the stall so the next op is taken on the same edge.
   always_comb begin
      state_nx  = state;
      data_req  = 1'b0;
      mem_stall = 1'b0;
      complete  = 1'b0;
      case (state)
         ST_REQ: begin
            data_req = 1'b1;
            if (data_addr_ok && data_data_ok) begin
               complete = 1'b1;
            end else begin
               mem_stall = 1'b1;
               if (data_addr_ok) state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (data_data_ok) complete = 1'b1;
            else              mem_stall = 1'b1;
         end
         default: ;
      endcase
      if (!mem_stall)
         state_nx = (ex_valid && ex_mem && !ex_misalign) ? ST_REQ : ST_IDLE;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // EX/MEM register: loads whenever not stalled; ex_valid=0 becomes a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q <= '0;
      end else if (!mem_stall) begin
         m_q.valid <= ex_valid;
         if (ex_valid) begin
            m_q.alu_result <= alu_result;
            m_q.store_data <= store_data;
            m_q.mem_read   <= mem_read_in;
            m_q.mem_write  <= mem_write_in;
            m_q.size       <= mem_size;
            m_q.sext       <= mem_sext;
            m_q.write_reg  <= write_reg;
            m_q.reg_write  <= reg_write_in;
            m_q.mem_to_reg <= mem_to_reg_in;
         end
      end
   end

   // Effective low address bits: words always lane 0; with checking off,
   // halves drop bit 0 instead of faulting.
   always_comb begin
      lane_a = m_q.alu_result[1:0];
      if (m_q.size[1])
         lane_a = 2'b00;
      else if ((m_q.size == MEM_SIZE_HALF) && (ALIGN_CHECK == 0))
         lane_a[0] = 1'b0;
   end

   mem_lane_align u_align (
      .size       (m_q.size),
      .addr_lo    (lane_a),
      .store_data (m_q.store_data),
      .rdata      (data_rdata),
      .sext       (m_q.sext),
      .wdata      (lane_wdata),
      .wstrb      (lane_wstrb),
      .load_data  (load_data)
   );

   // Bus side: held straight from M so it stays stable through REQ.
   assign data_wr    = bus_active & m_q.mem_write;
   assign data_size  = m_q.size;
   assign data_addr  = {m_q.alu_result[ADDR_W-1:2], lane_a};
   assign data_wstrb = (bus_active && m_q.mem_write) ? lane_wstrb : 4'b0000;
   assign data_wdata = lane_wdata;

   // Writeback beat: idle non-mem/faulting ops, or the data_ok cycle.
   assign wb_valid = complete | ((state == ST_IDLE) & m_q.valid & (!m_mem | m_misalign));
   assign wb_we    = wb_valid & m_q.reg_write & ~m_q.mem_write & ~m_fault;
   assign wb_waddr = m_q.write_reg;
   assign wb_wdata = m_q.mem_to_reg ? load_data : m_q.alu_result;

   assign adel      = m_fault & m_q.mem_read;
   assign ades      = m_fault & m_q.mem_write;
   assign bad_vaddr = m_fault ? m_q.alu_result[ADDR_W-1:0] : '0;

endmodule
